// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle FETCH/DECODE/EXEC/MEM/WB control unit driving the
// datapath enables, mux selects and the 6-bit ALU function code.
// Optional feature: define MC_CTRL_JAL_EN to support jal (opcode 000011);
// without it jal decodes as illegal and traps.
// Only the state register is stored; every control output is decoded
// combinationally from the state, the instruction and the handshake inputs,
// so an asynchronous reset forces all outputs low immediately.
module mc_ctrl (
  input  logic        clk,
  input  logic        nrst,
  input  logic [31:0] inst,
  input  logic        imem_rdy,
  input  logic        dmem_rdy,
  input  logic [31:0] alu_res,
  output logic        imem_req,
  output logic        ir_en,
  output logic        pc_en,
  output logic [1:0]  pc_sel,
  output logic [5:0]  alu_op,
  output logic        alu_srcb,
  output logic        dmem_req,
  output logic        dmem_wr,
  output logic        rf_wr,
  output logic [1:0]  rf_dst_sel,
  output logic [1:0]  rf_wd_sel,
  output logic        illegal,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd7
  } state_e;

  // Instruction class, resolved once from opcode/funct
  typedef enum logic [3:0] {
    CLS_ILL  = 4'd0,
    CLS_RALU = 4'd1,
    CLS_JR   = 4'd2,
    CLS_ADDI = 4'd3,
    CLS_LW   = 4'd4,
    CLS_SW   = 4'd5,
    CLS_BEQ  = 4'd6,
    CLS_BNE  = 4'd7,
    CLS_J    = 4'd8,
    CLS_JAL  = 4'd9
  } cls_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [5:0] ALU_ADD  = 6'b100000;
  localparam logic [5:0] ALU_BEQ  = 6'b000100;
  localparam logic [5:0] ALU_BNE  = 6'b000101;

  state_e     r_state;
  cls_e       w_cls;
  logic [5:0] w_opcode;
  logic [5:0] w_funct;
  logic       w_taken;
  logic       w_unused;

  assign w_opcode = inst[31:26];
  assign w_funct  = inst[5:0];
  assign w_taken  = alu_res[0];
  assign state    = r_state;

  // Register fields and upper ALU result bits are not needed for control
  assign w_unused = ^{inst[25:6], alu_res[31:1]};

  // Classify the instruction; anything not listed is illegal
  always_comb begin
    w_cls = CLS_ILL;
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_SUB, FN_SLT, FN_SLL, FN_SRL: w_cls = CLS_RALU;
          FN_JR:                                  w_cls = CLS_JR;
          default:                                w_cls = CLS_ILL;
        endcase
      end
      OP_ADDI: w_cls = CLS_ADDI;
      OP_LW:   w_cls = CLS_LW;
      OP_SW:   w_cls = CLS_SW;
      OP_BEQ:  w_cls = CLS_BEQ;
      OP_BNE:  w_cls = CLS_BNE;
      OP_J:    w_cls = CLS_J;
`ifdef MC_CTRL_JAL_EN
      OP_JAL:  w_cls = CLS_JAL;
`else
      OP_JAL:  w_cls = CLS_ILL;
`endif
      default: w_cls = CLS_ILL;
    endcase
  end

  // Sequencer: advance one instruction phase per cycle, waiting on memory handshakes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (imem_rdy) begin
            r_state <= ST_DECODE;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DECODE: begin
          if (w_cls == CLS_ILL) begin
            r_state <= ST_TRAP;
          end else begin
            r_state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (w_cls)
            CLS_RALU, CLS_ADDI, CLS_JAL: r_state <= ST_WB;
            CLS_LW, CLS_SW:              r_state <= ST_MEM;
            default:                     r_state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (dmem_rdy) begin
            if (w_cls == CLS_LW) begin
              r_state <= ST_WB;
            end else begin
              r_state <= ST_FETCH;
            end
          end else begin
            r_state <= ST_MEM;
          end
        end
        ST_WB:   r_state <= ST_FETCH;
        ST_TRAP: r_state <= ST_TRAP;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decode datapath controls from the current phase and instruction class
  always_comb begin
    imem_req   = 1'b0;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_sel     = 2'd0;
    alu_op     = 6'd0;
    alu_srcb   = 1'b0;
    dmem_req   = 1'b0;
    dmem_wr    = 1'b0;
    rf_wr      = 1'b0;
    rf_dst_sel = 2'd0;
    rf_wd_sel  = 2'd0;
    illegal    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_rdy) begin
          ir_en  = 1'b1;
          pc_en  = 1'b1;
          pc_sel = 2'd0;
        end else begin
          ir_en  = 1'b0;
          pc_en  = 1'b0;
        end
      end
      ST_EXEC: begin
        case (w_cls)
          CLS_RALU: begin
            alu_op   = w_funct;
            alu_srcb = 1'b0;
          end
          CLS_JR: begin
            pc_en  = 1'b1;
            pc_sel = 2'd3;
          end
          CLS_ADDI, CLS_LW, CLS_SW: begin
            alu_op   = ALU_ADD;
            alu_srcb = 1'b1;
          end
          CLS_BEQ: begin
            alu_op = ALU_BEQ;
            pc_sel = 2'd1;
            pc_en  = w_taken;
          end
          CLS_BNE: begin
            alu_op = ALU_BNE;
            pc_sel = 2'd1;
            pc_en  = w_taken;
          end
          CLS_J, CLS_JAL: begin
            pc_en  = 1'b1;
            pc_sel = 2'd2;
          end
          default: begin
            pc_en = 1'b0;
          end
        endcase
      end
      ST_MEM: begin
        // Address operands stay selected for the whole access
        dmem_req = 1'b1;
        dmem_wr  = (w_cls == CLS_SW);
        alu_op   = ALU_ADD;
        alu_srcb = 1'b1;
      end
      ST_WB: begin
        case (w_cls)
          CLS_RALU: begin
            rf_wr      = 1'b1;
            rf_dst_sel = 2'd1;
            rf_wd_sel  = 2'd0;
            alu_op     = w_funct;
          end
          CLS_ADDI: begin
            rf_wr      = 1'b1;
            rf_dst_sel = 2'd0;
            rf_wd_sel  = 2'd0;
            alu_op     = ALU_ADD;
            alu_srcb   = 1'b1;
          end
          CLS_LW: begin
            rf_wr      = 1'b1;
            rf_dst_sel = 2'd0;
            rf_wd_sel  = 2'd1;
          end
          CLS_JAL: begin
            rf_wr      = 1'b1;
            rf_dst_sel = 2'd2;
            rf_wd_sel  = 2'd2;
          end
          default: begin
            rf_wr = 1'b0;
          end
        endcase
      end
      ST_TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: directed instruction sequences; each cycle's expected
// control vector is queued by the stimulus and checked by a monitor on the
// falling clock edge.
module tb_mc_ctrl;

  logic        clk;
  logic        nrst;
  logic [31:0] inst;
  logic        imem_rdy;
  logic        dmem_rdy;
  logic [31:0] alu_res;
  logic        imem_req;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  pc_sel;
  logic [5:0]  alu_op;
  logic        alu_srcb;
  logic        dmem_req;
  logic        dmem_wr;
  logic        rf_wr;
  logic [1:0]  rf_dst_sel;
  logic [1:0]  rf_wd_sel;
  logic        illegal;
  logic [2:0]  state;

  typedef struct {
    string       nm;
    logic [22:0] v;
  } exp_t;

  exp_t        sb_q[$];
  int          n_tests;
  int          n_fail;
  logic [22:0] act;

  mc_ctrl dut (
    .clk(clk), .nrst(nrst), .inst(inst), .imem_rdy(imem_rdy),
    .dmem_rdy(dmem_rdy), .alu_res(alu_res), .imem_req(imem_req),
    .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .alu_op(alu_op),
    .alu_srcb(alu_srcb), .dmem_req(dmem_req), .dmem_wr(dmem_wr),
    .rf_wr(rf_wr), .rf_dst_sel(rf_dst_sel), .rf_wd_sel(rf_wd_sel),
    .illegal(illegal), .state(state)
  );

  assign act = {state, imem_req, ir_en, pc_en, pc_sel, alu_op, alu_srcb,
                dmem_req, dmem_wr, rf_wr, rf_dst_sel, rf_wd_sel, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pack an expected control vector in the same order as act
  function automatic logic [22:0] ev(input logic [2:0] st, input logic ireq,
      input logic ir, input logic pce, input logic [1:0] pcs,
      input logic [5:0] op, input logic sb, input logic dq, input logic dw,
      input logic rw, input logic [1:0] ds, input logic [1:0] wd,
      input logic il);
    return {st, ireq, ir, pce, pcs, op, sb, dq, dw, rw, ds, wd, il};
  endfunction

  // Queue the expectation for the current cycle, then advance one cycle
  task automatic tick(input string nm, input logic [22:0] v);
    exp_t e;
    e.nm = nm;
    e.v  = v;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    nrst = 1'b0;
    tick({nm, "_rst"}, ev(3'd0, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    nrst = 1'b1;
    tick({nm, "_idle"}, ev(3'd0, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
  endtask

  // Zero-wait fetch followed by the all-zero DECODE cycle
  task automatic fetch_decode(input string nm, input logic [31:0] ins);
    inst     = ins;
    imem_rdy = 1'b1;
    tick({nm, "_fetch"}, ev(3'd1, 1, 1, 1, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    imem_rdy = 1'b0;
    tick({nm, "_decode"}, ev(3'd2, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
  endtask

  // Monitor: compare DUT outputs with the oldest queued expectation
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t it;
      it = sb_q.pop_front();
      n_tests++;
      if (act !== it.v) begin
        n_fail++;
        $display("FAIL %s: actual=%h required=%h", it.nm, act, it.v);
      end
    end
  end

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    nrst     = 1'b0;
    inst     = 32'd0;
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    alu_res  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("init");

    // add $8,$9,$10
    fetch_decode("add", 32'h012A4020);
    tick("add_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b100000, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    tick("add_wb",   ev(3'd5, 0, 0, 0, 2'd0, 6'b100000, 0, 0, 0, 1, 2'd1, 2'd0, 0));

    // lw with one imem wait and a 2-cycle dmem wait; stray imem_rdy ignored in MEM
    inst = 32'h8D280004;
    tick("lw_fwait", ev(3'd1, 1, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    fetch_decode("lw", 32'h8D280004);
    tick("lw_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b100000, 1, 0, 0, 0, 2'd0, 2'd0, 0));
    imem_rdy = 1'b1;
    tick("lw_mem0", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 0, 0, 2'd0, 2'd0, 0));
    imem_rdy = 1'b0;
    tick("lw_mem1", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 0, 0, 2'd0, 2'd0, 0));
    dmem_rdy = 1'b1;
    tick("lw_mem2", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 0, 0, 2'd0, 2'd0, 0));
    dmem_rdy = 1'b0;
    tick("lw_wb", ev(3'd5, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 1, 2'd0, 2'd1, 0));

    // beq taken, then not taken
    fetch_decode("beqt", 32'h11090003);
    alu_res = 32'd1;
    tick("beqt_exec", ev(3'd3, 0, 0, 1, 2'd1, 6'b000100, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    fetch_decode("beqn", 32'h11090003);
    alu_res = 32'hFFFF_FFFE;
    tick("beqn_exec", ev(3'd3, 0, 0, 0, 2'd1, 6'b000100, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    alu_res = 32'd0;

    // bne taken
    fetch_decode("bne", 32'h15090003);
    alu_res = 32'd1;
    tick("bne_exec", ev(3'd3, 0, 0, 1, 2'd1, 6'b000101, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    alu_res = 32'd0;

    // j and jr
    fetch_decode("j", 32'h08000010);
    tick("j_exec", ev(3'd3, 0, 0, 1, 2'd2, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    fetch_decode("jr", 32'h01000008);
    tick("jr_exec", ev(3'd3, 0, 0, 1, 2'd3, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));

    // addi and slt
    fetch_decode("addi", 32'h21280005);
    tick("addi_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b100000, 1, 0, 0, 0, 2'd0, 2'd0, 0));
    tick("addi_wb",   ev(3'd5, 0, 0, 0, 2'd0, 6'b100000, 1, 0, 0, 1, 2'd0, 2'd0, 0));
    fetch_decode("slt", 32'h012A402A);
    tick("slt_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b101010, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    tick("slt_wb",   ev(3'd5, 0, 0, 0, 2'd0, 6'b101010, 0, 0, 0, 1, 2'd1, 2'd0, 0));

    // sw with zero-wait dmem
    fetch_decode("sw", 32'hAD280000);
    tick("sw_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b100000, 1, 0, 0, 0, 2'd0, 2'd0, 0));
    dmem_rdy = 1'b1;
    tick("sw_mem", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 1, 0, 2'd0, 2'd0, 0));
    dmem_rdy = 1'b0;

    // sw stalled in MEM, then reset lands mid-access
    fetch_decode("swr", 32'hAD280000);
    tick("swr_exec", ev(3'd3, 0, 0, 0, 2'd0, 6'b100000, 1, 0, 0, 0, 2'd0, 2'd0, 0));
    tick("swr_mem0", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 1, 0, 2'd0, 2'd0, 0));
    tick("swr_mem1", ev(3'd4, 0, 0, 0, 2'd0, 6'b100000, 1, 1, 1, 0, 2'd0, 2'd0, 0));
    do_reset("swr");
    tick("swr_refetch", ev(3'd1, 1, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));

    // jal: supported only with the optional feature
    fetch_decode("jal", 32'h0C000010);
`ifdef MC_CTRL_JAL_EN
    tick("jal_exec", ev(3'd3, 0, 0, 1, 2'd2, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));
    tick("jal_wb",   ev(3'd5, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 1, 2'd2, 2'd2, 0));
`else
    tick("jal_trap", ev(3'd7, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1));
    do_reset("jal");
`endif

    // Illegal opcode traps and ignores imem_rdy until reset
    fetch_decode("ill", 32'hFC000000);
    imem_rdy = 1'b1;
    dmem_rdy = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick("ill_trap", ev(3'd7, 0, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 1));
    end
    imem_rdy = 1'b0;
    dmem_rdy = 1'b0;
    do_reset("ill");
    tick("ill_refetch", ev(3'd1, 1, 0, 0, 2'd0, 6'd0, 0, 0, 0, 0, 2'd0, 2'd0, 0));

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (sb_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: actual=%0d pending required=0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
